// File: rtl/dsp_pkg.sv
// dsp_pkg: shared constants and types for DSP48A1 slice controllers
package dsp_pkg;
  localparam int A_W = 18;
  localparam int P_W = 48;
  localparam logic [7:0] OPM_MULT = 8'h01;
  localparam logic [7:0] OPM_MAC = 8'h09;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} fir_state_e;
endpackage

// File: rtl/dsp_opmode_delay.sv
// dsp_opmode_delay: DEPTH-stage 8-bit opmode shift register with async clear
// Ports: clk, rst (async, active-high), opm_i (opmode in), opm_o (opmode DEPTH cycles later)
module dsp_opmode_delay #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] opm_i,
  output logic [7:0] opm_o
);
  if (DEPTH == 0) begin : g_pass
    assign opm_o = opm_i;
  end else begin : g_sr
    logic [7:0] sr_q [DEPTH];
    always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
      else begin
        sr_q[0] <= opm_i;
        for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
      end
    assign opm_o = sr_q[DEPTH-1];
  end
endmodule

// File: rtl/dsp_fir_sequencer.sv
// dsp_fir_sequencer: time-multiplexed FIR controller driving one DSP48A1 slice
// Ports: CLK/RST (async active-high); S_* sample stream in; COEF_* coefficient writes;
// M_* 48-bit result stream out; DSP_* operands/opmode/CE/RST to the slice, DSP_P back.
module dsp_fir_sequencer
  import dsp_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int PIPE_LAT = 3,
  parameter int OPM_DELAY = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      S_VALID,
  output logic                      S_READY,
  input  logic [A_W-1:0]            S_DATA,
  input  logic                      COEF_WE,
  input  logic [$clog2(NTAPS)-1:0]  COEF_ADDR,
  input  logic [A_W-1:0]            COEF_DATA,
  output logic                      M_VALID,
  input  logic                      M_READY,
  output logic [P_W-1:0]            M_DATA,
  output logic [A_W-1:0]            DSP_A,
  output logic [A_W-1:0]            DSP_B,
  output logic [A_W-1:0]            DSP_D,
  output logic [P_W-1:0]            DSP_C,
  output logic [7:0]                DSP_OPMODE,
  output logic                      DSP_CE,
  output logic                      DSP_RST,
  input  logic [P_W-1:0]            DSP_P
);
  localparam int AW = $clog2(NTAPS);
  localparam int CW = $clog2(NTAPS > PIPE_LAT ? NTAPS : PIPE_LAT) + 1;
  fir_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [A_W-1:0] x_q [NTAPS];
  logic [A_W-1:0] coef_q [NTAPS];
  logic [P_W-1:0] m_data_q;
  logic m_valid_q, dsp_rst_q, up_q;
  logic issue, drain, accept, tap_last, drain_last;
  logic [AW-1:0] idx;
  logic [7:0] tap_opm;
  assign issue = state_q == ISSUE;
  assign drain = state_q == DRAIN;
  assign idx = cnt_q[AW-1:0];
  assign tap_last = cnt_q == CW'(NTAPS - 1);
  assign drain_last = cnt_q == CW'(PIPE_LAT - 1);
  // up_q delays S_READY one cycle past the slice reset release
  assign S_READY = up_q && state_q == IDLE;
  assign accept = S_VALID && S_READY;
  assign M_VALID = m_valid_q;
  assign M_DATA = m_data_q;
  assign DSP_A = issue ? x_q[idx] : '0;
  assign DSP_B = issue ? coef_q[idx] : '0;
  assign DSP_D = '0;
  assign DSP_C = '0;
  assign DSP_CE = issue || drain;
  assign DSP_RST = dsp_rst_q;
  // drain keeps Z=P with zero operands so P holds the final sum into OUT
  assign tap_opm = issue ? (cnt_q == '0 ? OPM_MULT : OPM_MAC) : drain ? OPM_MAC : 8'h00;
  dsp_opmode_delay #(.DEPTH(OPM_DELAY)) u_opm (
    .clk(CLK),
    .rst(RST),
    .opm_i(tap_opm),
    .opm_o(DSP_OPMODE)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ISSUE;
        cnt_d = '0;
      end
      ISSUE: begin
        state_d = tap_last ? DRAIN : ISSUE;
        cnt_d = tap_last ? '0 : cnt_q + 1'b1;
      end
      DRAIN: begin
        state_d = drain_last ? OUT : DRAIN;
        cnt_d = drain_last ? '0 : cnt_q + 1'b1;
      end
      OUT: state_d = M_READY ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= IDLE;
      cnt_q <= '0;
      m_data_q <= '0;
      m_valid_q <= 1'b0;
      dsp_rst_q <= 1'b1;
      up_q <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      dsp_rst_q <= 1'b0;
      up_q <= ~dsp_rst_q;
      if (accept) begin
        x_q[0] <= S_DATA;
        for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
      end
      if (COEF_WE && 32'(COEF_ADDR) < NTAPS) coef_q[COEF_ADDR] <= COEF_DATA;
      if (drain && drain_last) begin
        m_data_q <= DSP_P;
        m_valid_q <= 1'b1;
      end else if (state_q == OUT && M_READY) m_valid_q <= 1'b0;
    end
endmodule

// File: tb/tb_dsp_fir_sequencer.sv
// tb_dsp_fir_sequencer: randomized check of the FIR sequencer against an arithmetic FIR model
module tb_dsp_fir_sequencer;
  localparam int NT = 4;
  localparam int PL = 3;
  localparam int OD = 1;
  logic CLK = 0, RST = 1, S_VALID = 0, COEF_WE = 0, M_READY = 0;
  logic [17:0] S_DATA = '0, COEF_DATA = '0;
  logic [1:0] COEF_ADDR = '0;
  logic S_READY, M_VALID, DSP_CE, DSP_RST;
  logic [17:0] DSP_A, DSP_B, DSP_D;
  logic [47:0] M_DATA, DSP_C, DSP_P;
  logic [7:0] DSP_OPMODE;
  int checks = 0, errors = 0;
  always #5 CLK = ~CLK;
  dsp_fir_sequencer #(.NTAPS(NT), .PIPE_LAT(PL), .OPM_DELAY(OD)) dut (
    .CLK(CLK), .RST(RST), .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR), .COEF_DATA(COEF_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .DSP_A(DSP_A), .DSP_B(DSP_B), .DSP_D(DSP_D), .DSP_C(DSP_C),
    .DSP_OPMODE(DSP_OPMODE), .DSP_CE(DSP_CE), .DSP_RST(DSP_RST), .DSP_P(DSP_P)
  );
  // slice: A1/B1 -> M -> P, OPMODE registered once, sync reset, common CE
  logic signed [17:0] a1, b1;
  logic signed [35:0] m;
  logic [7:0] opm_r;
  logic [47:0] p;
  assign DSP_P = p;
  always @(posedge CLK)
    if (DSP_RST) begin
      a1 <= '0; b1 <= '0; m <= '0; opm_r <= '0; p <= '0;
    end else if (DSP_CE) begin
      a1 <= DSP_A;
      b1 <= DSP_B;
      m <= a1 * b1;
      opm_r <= DSP_OPMODE;
      p <= (opm_r[1:0] == 2'b01 ? {{12{m[35]}}, m} : 48'd0) + (opm_r[3:2] == 2'b10 ? p : 48'd0);
    end
  logic [17:0] hist [NT];
  logic [17:0] cf [NT];
  int imp_exp [NT] = '{2, 3, 4, 5};
  int stp_exp [NT] = '{2, 5, 9, 14};
  int base_cf [NT] = '{2, 3, 4, 5};
  function automatic logic [47:0] fir_ref();
    longint acc = 0;
    for (int k = 0; k < NT; k++) acc += longint'($signed(cf[k])) * longint'($signed(hist[k]));
    return acc[47:0];
  endfunction
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic check_reset();
    check("rst_s_ready", 48'(S_READY), 48'd0);
    check("rst_m_valid", 48'(M_VALID), 48'd0);
    check("rst_m_data", M_DATA, 48'd0);
    check("rst_dsp_a", 48'(DSP_A), 48'd0);
    check("rst_dsp_b", 48'(DSP_B), 48'd0);
    check("rst_opmode", 48'(DSP_OPMODE), 48'd0);
    check("rst_ce", 48'(DSP_CE), 48'd0);
    check("rst_dsp_rst", 48'(DSP_RST), 48'd1);
  endtask
  task automatic wr_coef(input int a, input logic [17:0] d);
    COEF_WE = 1; COEF_ADDR = 2'(a); COEF_DATA = d;
    @(negedge CLK);
    COEF_WE = 0;
    cf[a] = d;
  endtask
  task automatic load(input int c [NT]);
    for (int k = 0; k < NT; k++) wr_coef(k, 18'(c[k]));
  endtask
  task automatic xfer(input logic [17:0] s, input int hold, input int abort, output logic [47:0] got);
    int n;
    logic [47:0] e;
    got = '0;
    S_VALID = 1; S_DATA = s; n = 0;
    while (!S_READY && n < 50) begin @(negedge CLK); n++; end
    check("s_ready_wait", 48'(S_READY), 48'd1);
    if (!S_READY) begin S_VALID = 0; return; end
    @(negedge CLK);
    S_VALID = 0; S_DATA = 18'($urandom);
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    e = fir_ref();
    for (int j = 0; j < NT + OD; j++) begin
      if (j == abort) begin
        RST = 1;
        #1 check_reset();
        return;
      end
      check("opmode", 48'(DSP_OPMODE), 48'(j < OD ? 8'h00 : j == OD ? 8'h01 : 8'h09));
      if (j < NT) begin
        check("dsp_a", 48'(DSP_A), 48'(hist[j]));
        check("dsp_b", 48'(DSP_B), 48'(cf[j]));
        check("ce_issue", 48'(DSP_CE), 48'd1);
        check("s_ready_busy", 48'(S_READY), 48'd0);
      end
      @(negedge CLK);
    end
    n = 0;
    while (!M_VALID && n < 20) begin @(negedge CLK); n++; end
    check("m_latency", 48'(n), 48'(PL - OD));
    if (!M_VALID) return;
    got = M_DATA;
    check("m_data", M_DATA, e);
    for (int i = 0; i < hold; i++) begin
      check("hold_m_valid", 48'(M_VALID), 48'd1);
      check("hold_m_data", M_DATA, e);
      check("hold_s_ready", 48'(S_READY), 48'd0);
      check("hold_ce", 48'(DSP_CE), 48'd0);
      check("hold_dsp_p", DSP_P, e);
      @(negedge CLK);
    end
    M_READY = 1;
    @(negedge CLK);
    M_READY = 0;
    check("m_valid_drop", 48'(M_VALID), 48'd0);
    check("s_ready_back", 48'(S_READY), 48'd1);
  endtask
  initial begin
    logic [47:0] got;
    int rc [NT];
    for (int k = 0; k < NT; k++) begin hist[k] = '0; cf[k] = '0; end
    repeat (3) @(negedge CLK);
    check_reset();
    RST = 0;
    @(negedge CLK);
    check("dsp_rst_release", 48'(DSP_RST), 48'd0);
    check("s_ready_release0", 48'(S_READY), 48'd0);
    @(negedge CLK);
    check("s_ready_release1", 48'(S_READY), 48'd1);
    load(base_cf);
    for (int i = 0; i < NT; i++) begin
      xfer(i == 0 ? 18'd1 : 18'd0, $urandom_range(0, 2), -1, got);
      check("impulse", got, 48'(imp_exp[i]));
    end
    for (int i = 0; i < NT; i++) begin
      xfer(18'd1, $urandom_range(0, 2), -1, got);
      check("step", got, 48'(stp_exp[i]));
    end
    rc = '{3, 0, 0, 0};
    load(rc);
    xfer(18'h3FFFF, 10, -1, got);
    check("neg_one", got, 48'hFFFF_FFFF_FFFD);
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) begin
        for (int k = 0; k < NT; k++) rc[k] = int'($urandom_range(0, 32'h3FFFF));
        load(rc);
      end
      xfer(18'($urandom), $urandom_range(0, 3), -1, got);
    end
    load(base_cf);
    xfer(18'h155, 0, 2, got);
    @(negedge CLK);
    check_reset();
    RST = 0;
    for (int k = 0; k < NT; k++) begin hist[k] = '0; cf[k] = '0; end
    @(negedge CLK);
    check("dsp_rst_rerelease", 48'(DSP_RST), 48'd0);
    load(base_cf);
    for (int i = 0; i < NT; i++) begin
      xfer(18'd1, 1, -1, got);
      check("step_after_abort", got, 48'(stp_exp[i]));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
